iterative_right_shifter: RTL

Multi-cycle 32-bit right-shift unit for the ALU shift path. It is the right-direction counterpart to the left-shift stage network, covering logical (SRL) and arithmetic (SRA) shifts. It applies one binary-weighted shift stage per cycle (16, 8, 4, 2, 1) under a start/busy/done handshake. This trades a fixed SHW-cycle latency for a single shared stage datapath.

---
 rtl/iterative_right_shifter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/iterative_right_shifter.sv
// iterative_right_shifter: multi-cycle logical/arithmetic right shifter.
// Applies one binary-weighted stage per cycle (WIDTH/2, ..., 2, 1) to a
// single working register, so the latency is always SHW cycles.
//
// Ports:
//   clock    - system clock, rising-edge active
//   reset    - synchronous, active-high reset (priority over start)
//   start    - request, accepted only while busy=0
//   data_in  - operand, latched on an accepted start
//   shamt    - shift amount 0..WIDTH-1, latched on an accepted start
//   arith    - 1 = SRA (sign fill), 0 = SRL (zero fill)
//   result   - shifted value, valid with done and held until next start
//   busy     - high while a shift is in progress
//   done     - one-cycle pulse marking result valid
module iterative_right_shifter #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SHW   = 5
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] data_in,
   input  logic [SHW-1:0]   shamt,
   input  logic             arith,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done
);

   // Stage counter must be able to hold 0..SHW.
   localparam int unsigned CW = $clog2(SHW + 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic [CW-1:0]    stage;
   logic [CW-1:0]    stage_nxt;
   logic [SHW-1:0]   shamt_q;
   logic [SHW-1:0]   shamt_nxt;
   // fill = arith & original MSB; it is the only use of the latched arith.
   logic             fill_q;
   logic             fill_nxt;
   logic [WIDTH-1:0] result_nxt;
   logic             busy_nxt;
   logic             done_nxt;

   logic             accept_c;
   logic [CW-1:0]    bit_idx_c;
   logic [SHW-1:0]   dist_c;
   logic [WIDTH-1:0] shifted_c;

   // A start is taken in IDLE or DONE, i.e. whenever no shift is in flight.
   assign accept_c = start && (state != SHIFT);

   // Stage k examines shamt bit SHW-1-k and shifts by 2**(SHW-1-k).
   assign bit_idx_c = CW'(SHW - 1) - stage;
   assign dist_c    = SHW'(1) << bit_idx_c;
   assign shifted_c = (result >> dist_c)
                    | ({WIDTH{fill_q}} & ~({WIDTH{1'b1}} >> dist_c));

   // State register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) state_nxt = SHIFT;
         end
         SHIFT: begin
            if (stage == CW'(SHW - 1)) state_nxt = DONE;
         end
         DONE: begin
            state_nxt = start ? SHIFT : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output / datapath next values.
   always_comb begin
      result_nxt = result;
      stage_nxt  = stage;
      shamt_nxt  = shamt_q;
      fill_nxt   = fill_q;
      busy_nxt   = (state_nxt == SHIFT);
      done_nxt   = (state_nxt == DONE);
      if (accept_c) begin
         result_nxt = data_in;
         shamt_nxt  = shamt;
         fill_nxt   = arith & data_in[WIDTH-1];
         stage_nxt  = '0;
      end else if (state == SHIFT) begin
         if (shamt_q[bit_idx_c]) result_nxt = shifted_c;
         stage_nxt = stage + CW'(1);
      end
   end

   // Registered outputs and latched operands.
   always_ff @(posedge clock) begin
      if (reset) begin
         result  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         stage   <= '0;
         shamt_q <= '0;
         fill_q  <= 1'b0;
      end else begin
         result  <= result_nxt;
         busy    <= busy_nxt;
         done    <= done_nxt;
         stage   <= stage_nxt;
         shamt_q <= shamt_nxt;
         fill_q  <= fill_nxt;
      end
   end

endmodule
